// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between the CPU and a DMA/debug requester
// One access in flight at a time; CPU wins ties until it has starved a waiting DMA STARVE_MAX times.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_cclk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_ack,
    output logic              o_cpu_stall,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_dma_ack,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [1:0]        o_owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OWN_NONE   = 2'b00;
    localparam logic [1:0] OWN_CPU    = 2'b01;
    localparam logic [1:0] OWN_DMA    = 2'b10;
    localparam logic [3:0] LAT_LAST   = 4'(MEM_LAT);
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_wait_cnt;
    logic [3:0]        r_starve_cnt;
    logic              r_we;
    logic [DATA_W-1:0] r_data;
    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_cpu_ack;
    logic              r_dma_ack;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dma_rdata;
    logic [1:0]        r_owner;

    logic              w_any_req;
    logic              w_grant_cpu;
    logic              w_grant_dma;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_wait_done;
    logic              w_capture;
    logic [DATA_W-1:0] w_done_data;

    logic              w_mem_en_nxt;
    logic              w_mem_we_nxt;
    logic              w_cpu_ack_nxt;
    logic              w_dma_ack_nxt;
    logic [1:0]        w_owner_nxt;
    logic [3:0]        w_wait_nxt;
    logic [3:0]        w_starve_nxt;

    // Tie goes to the CPU unless the DMA has already been passed over STARVE_MAX times.
    assign w_any_req   = i_cpu_req | i_dma_req;
    assign w_grant_cpu = i_cpu_req & (~i_dma_req | (r_starve_cnt != STARVE_LIM));
    assign w_grant_dma = i_dma_req & ~w_grant_cpu;
    assign w_sel_we    = w_grant_dma ? i_dma_we    : i_cpu_we;
    assign w_sel_addr  = w_grant_dma ? i_dma_addr  : i_cpu_addr;
    assign w_sel_wdata = w_grant_dma ? i_dma_wdata : i_cpu_wdata;

    assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == LAT_LAST);
    assign w_capture   = w_wait_done & ~r_we;
    assign w_done_data = w_capture ? i_mem_rdata : r_data;

    always_ff @(posedge i_cclk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (w_wait_done) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        w_mem_en_nxt  = (w_state_nxt == S_ISSUE);
        w_mem_we_nxt  = w_mem_en_nxt & w_sel_we;
        w_cpu_ack_nxt = (w_state_nxt == S_DONE) && (r_owner == OWN_CPU);
        w_dma_ack_nxt = (w_state_nxt == S_DONE) && (r_owner == OWN_DMA);

        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                if (w_grant_cpu)      w_owner_nxt = OWN_CPU;
                else if (w_grant_dma) w_owner_nxt = OWN_DMA;
                else                  w_owner_nxt = OWN_NONE;
            end
            S_DONE:  w_owner_nxt = OWN_NONE;
            default: w_owner_nxt = r_owner;
        endcase

        w_wait_nxt = 4'd0;
        if (r_state == S_ISSUE) begin
            w_wait_nxt = 4'd1;
        end else if ((r_state == S_WAIT) && !w_wait_done) begin
            w_wait_nxt = r_wait_cnt + 4'd1;
        end

        w_starve_nxt = r_starve_cnt;
        if (r_state == S_IDLE) begin
            if (w_grant_cpu && i_dma_req) begin
                w_starve_nxt = r_starve_cnt + 4'd1;
            end else if (w_any_req) begin
                w_starve_nxt = 4'd0;
            end
        end
    end

    always_ff @(posedge i_cclk) begin
        if (i_rst) begin
            r_wait_cnt   <= 4'd0;
            r_starve_cnt <= 4'd0;
            r_we         <= 1'b0;
            r_data       <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dma_rdata  <= '0;
            r_owner      <= OWN_NONE;
        end else begin
            r_wait_cnt   <= w_wait_nxt;
            r_starve_cnt <= w_starve_nxt;
            r_mem_en     <= w_mem_en_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_cpu_ack    <= w_cpu_ack_nxt;
            r_dma_ack    <= w_dma_ack_nxt;
            r_owner      <= w_owner_nxt;
            if (w_mem_en_nxt) begin
                r_we        <= w_sel_we;
                r_mem_addr  <= w_sel_addr;
                r_mem_wdata <= w_sel_wdata;
            end
            if (w_capture) begin
                r_data <= i_mem_rdata;
            end
            if (w_cpu_ack_nxt) begin
                r_cpu_rdata <= w_done_data;
            end
            if (w_dma_ack_nxt) begin
                r_dma_rdata <= w_done_data;
            end
        end
    end

    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_cpu_ack   = r_cpu_ack;
    assign o_dma_ack   = r_dma_ack;
    assign o_cpu_rdata = r_cpu_rdata;
    assign o_dma_rdata = r_dma_rdata;
    assign o_owner     = r_owner;
    assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;

endmodule
